apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Requester (initiator) end of the team's APB4 interconnect; drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB bus that the slave-side memories decode.
- Accepts single byte/half/word commands on a valid/ready channel and encodes size plus address into PSTRB.
- Runs the two-phase APB transfer, then returns PRDATA/PSLVERR on a valid/ready response channel.
- One outstanding transfer at a time. Sits between a simple CPU/DMA port and the APB fabric.

Parameters:
- AddrWidth, 32, PADDR and command address width.
- DataWidth, 32, PWDATA/PRDATA width. Fixed at 32 in this revision; PSTRB is 4 bits.
- TimeoutCycles, 256, ACCESS-phase wait limit. Used only when APB_TIMEOUT_EN is defined; minimum 2.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AddrWidth  byte address.
- cmd_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- cmd_wdata  in  32  write data, already lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_rdata  out  32  captured PRDATA; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, alignment error, or timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AddrWidth  APB address.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB write strobes.
- PREADY, PSLVERR  in  1 each  APB completer response.
- PRDATA  in  32  APB read data.

Behaviour:
- Reset (async, PRESETn=0): state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata and rsp_err all 0. cmd_ready=0 while in reset.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- cmd_ready is 1 only in IDLE (combinational from the state register).
- Strobe encoding uses lane = cmd_addr[1:0]:
  - byte: PSTRB = 4'b0001 << lane.
  - half: PSTRB = 4'b0011 << lane; lane 3 is misaligned.
  - word: PSTRB = 4'b1111; lane != 0 is misaligned.
  - size 3 is always misaligned.
- Reads drive PSTRB = 0 (APB4 rule). The misalignment check still applies to reads.
- PADDR = cmd_addr, unmodified.
- IDLE, handshake with an aligned command: register the bus fields, PSEL=1, PENABLE=0, go to SETUP.
- IDLE, handshake with a misaligned command: no bus activity. Go to RESP with rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS.
- ACCESS with PREADY=0: hold all bus signals stable.
- ACCESS with PREADY=1:
  - Capture PSLVERR into rsp_err.
  - For reads, capture PRDATA into rsp_rdata, or 0 if PSLVERR=1. For writes, rsp_rdata=0.
  - Drop PSEL and PENABLE, set rsp_valid=1, go to RESP.
- RESP: hold rsp_* until rsp_ready=1, then rsp_valid=0 and go to IDLE.
  - The next cmd_ready is 1 in the following cycle, so there are no back-to-back transfers and at least one idle bus cycle between transfers.
- Minimum latency, cmd handshake to rsp_valid: 3 cycles (SETUP, then ACCESS with PREADY=1 on the first cycle, then RESP visible).
- Boundaries:
  - rsp_ready held high in RESP: response lasts one cycle.
  - PREADY asserted during SETUP is ignored.
  - PRESETn asserted mid-transfer aborts immediately: PSEL=0 and no response is produced.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A $clog2(TimeoutCycles+1)-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TimeoutCycles-1 with PREADY still 0, the next edge drops PSEL/PENABLE and goes to RESP with rsp_err=1, rsp_rdata=0.
  - PREADY=1 in that same cycle wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_pkg holds:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, RESP};
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - function strb_encode(size, lane, write) returning {misaligned, strb[3:0]}.
- One sub-module: apb_strb_encoder. Purely combinational, wraps strb_encode so it can be checked exhaustively on its own.

Test Plan:
- Write word 0xDEADBEEF to 0x10, PREADY=1 immediately -> PSEL at cycle+1, PENABLE at cycle+2, PSTRB=4'hF, PADDR=0x10, rsp_valid at cycle+3, rsp_err=0.
- Byte write to 0x13, then half write to 0x12 -> PSTRB=4'b1000, then 4'b1100; half write to 0x13 -> no PSEL, rsp_err=1 next cycle.
- Read 0x20 with PREADY low for 5 ACCESS cycles and PRDATA=0x12345678 -> PSEL/PENABLE/PADDR stable all 5 cycles, PSTRB=0, rsp_rdata=0x12345678.
- PSLVERR=1 with PREADY=1 on a read -> rsp_err=1, rsp_rdata=0. rsp_ready held low 3 cycles -> response stable, cmd_ready=0 throughout.
- PRESETn low during ACCESS -> all outputs 0 asynchronously, IDLE after release, no rsp_valid.
- APB_TIMEOUT_EN with TimeoutCycles=4 and PREADY never high -> exactly 4 ACCESS cycles, then rsp_err=1. PREADY rising on the 4th ACCESS cycle -> normal completion with rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, command size encodings and the APB4 strobe encoder.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    // Returns {misaligned, strb}; reads always carry a zero strobe.
    function automatic logic [4:0] strb_encode(input logic [1:0] size, input logic [1:0] lane, input logic write);
        logic       mis;
        logic [3:0] s;
        mis = size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? lane == 2'd3 : size == SIZE_WORD ? lane != 2'd0 : 1'b1;
        s = size == SIZE_BYTE ? 4'b0001 << lane : size == SIZE_HALF ? 4'b0011 << lane : size == SIZE_WORD ? 4'b1111 : 4'b0000;
        return {mis, write ? s : 4'b0000};
    endfunction
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response channels plus the APB4 requester bus.
interface apb_master_bridge_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 cmd_valid, cmd_ready, cmd_write;
    logic [AddrWidth-1:0] cmd_addr;
    logic [1:0]           cmd_size;
    logic [DataWidth-1:0] cmd_wdata;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AddrWidth-1:0] PADDR;
    logic [DataWidth-1:0] PWDATA, PRDATA;
    logic [3:0]           PSTRB;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_strb_encoder.sv
// apb_strb_encoder: combinational wrapper around strb_encode for standalone checking.
module apb_strb_encoder
    import apb_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] lane,
    input  logic       write,
    output logic       misaligned,
    output logic [3:0] strb
);
    assign {misaligned, strb} = strb_encode(size, lane, write);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB4 requester with valid/ready command and response channels.
// Define APB_TIMEOUT_EN to bound the ACCESS phase at TimeoutCycles cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input logic PCLK,
    input logic PRESETn,
    apb_master_bridge_if.master bus
);
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    apb_state_e           state_q, state_d;
    logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AddrWidth-1:0] paddr_q, paddr_d;
    logic [DataWidth-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                 mis, timeout;
    logic [3:0]           strb;

    apb_strb_encoder u_strb (
        .size      (bus.cmd_size),
        .lane      (bus.cmd_addr[1:0]),
        .write     (bus.cmd_write),
        .misaligned(mis),
        .strb      (strb)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] cnt_q;
    assign timeout = state_q == ACCESS && !bus.PREADY && cnt_q == CntWidth'(TimeoutCycles - 1);
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) cnt_q <= '0;
        else cnt_q <= state_q == SETUP ? '0 : (state_q == ACCESS && !bus.PREADY) ? cnt_q + 1'b1 : cnt_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.cmd_valid ? (mis ? RESP : SETUP) : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (bus.PREADY || timeout) ? RESP : ACCESS;
            default: state_d = bus.rsp_ready ? IDLE : RESP;
        endcase
    end

    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == IDLE && bus.cmd_valid && mis) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
        if (state_q == IDLE && bus.cmd_valid && !mis) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = bus.cmd_write;
            paddr_d   = bus.cmd_addr;
            pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_d   = strb;
        end
        if (state_q == SETUP) penable_d = 1'b1;
        // A timeout completes like an error response with no read data.
        if (state_q == ACCESS && (bus.PREADY || timeout)) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = bus.PSLVERR || !bus.PREADY;
            rsp_rdata_d = (bus.PREADY && !bus.PSLVERR && !pwrite_q) ? bus.PRDATA : '0;
        end
        if (state_q == RESP && bus.rsp_ready) rsp_valid_d = 1'b0;
    end

    assign bus.cmd_ready = state_q == IDLE && PRESETn;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
